// File: rtl/keypad_pkg.sv
// =============================================================================
// Module      : keypad_pkg
// Description : Shared types, row pattern and hex key map for the 4x4 keypad
//               scanner.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } keypad_state_t;

    localparam logic [3:0] ROW_INIT = 4'b1110;

    // Indexed {row, col}; col 0 is the leftmost column.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [7:0] twice;
        twice = {ROW_INIT, ROW_INIT} << idx;
        return twice[7:4];
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        if (!cols[0])      return 2'd0;
        else if (!cols[1]) return 2'd1;
        else if (!cols[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    function automatic logic exactly_one_low(input logic [3:0] cols);
        logic [3:0] low;
        low = ~cols;
        return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
// =============================================================================
// Module      : keypad_scanner_if
// Description : Keypad matrix pins plus the decoded key stream to the display.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

`default_nettype wire

// File: rtl/key_decode.sv
// =============================================================================
// Module      : key_decode
// Description : Combinational {row index, col index} to hex key code lookup.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module key_decode
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] code
);

    assign code = KEY_MAP[{row_idx, col_idx}];

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// =============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad row scanner with press/release debounce; emits one
//               hex code per accepted press. Option: KEYPAD_GHOST_REJECT_EN.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    keypad_scanner_if.master  kp
);

    localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [SCAN_W-1:0] DWELL_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] DWELL_ONE  = SCAN_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);

    logic [3:0]        col_meta;
    logic [3:0]        col_s;

    keypad_state_t     state,    state_nx;
    logic [1:0]        row_idx,  row_idx_nx;
    logic [1:0]        lcol,     lcol_nx;
    logic [SCAN_W-1:0] dwell,    dwell_nx;
    logic [DB_W-1:0]   db,       db_nx;
    logic [3:0]        code_q,   code_nx;
    logic              valid_q,  valid_nx;
    logic              held_q,   held_nx;

    logic [3:0]        decoded;
    logic              press_seen;
    logic              lcol_high;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= kp.col;
            col_s    <= col_meta;
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    // Two or more low columns on one row may be a ghost; treat as no press.
    assign press_seen = exactly_one_low(col_s);
`else
    assign press_seen = (col_s != 4'hF);
`endif

    assign lcol_high = col_s[lcol];

    key_decode u_key_decode (
        .row_idx (row_idx),
        .col_idx (lcol),
        .code    (decoded)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= SCAN;
            row_idx <= 2'd0;
            lcol    <= 2'd0;
            dwell   <= '0;
            db      <= '0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            row_idx <= row_idx_nx;
            lcol    <= lcol_nx;
            dwell   <= dwell_nx;
            db      <= db_nx;
            code_q  <= code_nx;
            valid_q <= valid_nx;
            held_q  <= held_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        row_idx_nx = row_idx;
        lcol_nx    = lcol;
        dwell_nx   = dwell;
        db_nx      = db;
        code_nx    = code_q;
        valid_nx   = 1'b0;
        held_nx    = held_q;

        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nx = '0;
                    if (press_seen) begin
                        lcol_nx  = lowest_low(col_s);
                        db_nx    = '0;
                        state_nx = PRESS_DB;
                    end else begin
                        row_idx_nx = row_idx + 2'd1;
                    end
                end else begin
                    dwell_nx = dwell + DWELL_ONE;
                end
            end

            PRESS_DB: begin
                if (lcol_high) begin
                    row_idx_nx = row_idx + 2'd1;
                    state_nx   = SCAN;
                end else if (db == DB_LAST) begin
                    code_nx  = decoded;
                    valid_nx = 1'b1;
                    held_nx  = 1'b1;
                    state_nx = HELD;
                end else begin
                    db_nx = db + DB_ONE;
                end
            end

            HELD: begin
                // Only the latched column matters; a second key is ignored.
                if (lcol_high) begin
                    db_nx    = '0;
                    state_nx = RELEASE_DB;
                end
            end

            RELEASE_DB: begin
                if (!lcol_high) begin
                    state_nx = HELD;
                end else if (db == DB_LAST) begin
                    held_nx    = 1'b0;
                    row_idx_nx = row_idx + 2'd1;
                    state_nx   = SCAN;
                end else begin
                    db_nx = db + DB_ONE;
                end
            end

            default: state_nx = SCAN;
        endcase
    end

    assign kp.row       = row_drive(row_idx);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// =============================================================================
// Module      : tb_keypad_scanner
// Description : Directed bench for keypad_scanner with a behavioural key matrix.
// Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_keypad_scanner;

    logic clk;
    logic reset_n;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV        (8),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed keys, bit index row*4+col; a pressed key pulls its column low
    // whenever its row is driven low.
    logic [15:0] keys;
    logic [3:0]  col_model;

    always_comb begin
        col_model = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp.row[r] && keys[r*4+c]) col_model[c] = 1'b0;
    end
    assign kp.col = col_model;

    int         n_checks;
    int         n_fail;
    int         pulses;
    int         double_pulses;
    logic       prev_valid;
    logic [3:0] row_pat [4];

    always @(negedge clk) begin
        if (kp.key_valid) pulses++;
        if (kp.key_valid && prev_valid) double_pulses++;
        prev_valid = kp.key_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns on the first negedge after the scan enters row r afresh.
    task automatic wait_row(input int r);
        int guard;
        guard = 0;
        while (kp.row == row_pat[r] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (kp.row != row_pat[r] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wait_row", {28'd0, kp.row}, {28'd0, row_pat[r]});
    endtask

    typedef struct {
        int         r;
        int         c;
        int         hold;
        int         exp_pulses;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int p0;
        n_checks      = 0;
        n_fail        = 0;
        pulses        = 0;
        double_pulses = 0;
        prev_valid    = 1'b0;
        keys          = 16'd0;
        reset_n       = 1'b0;
        row_pat       = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Hold times count negedges from row entry; 23 is the shortest
        // press that survives the 16-cycle debounce, 22 just misses.
        vecs[0] = '{2, 1, 200, 1, 4'h8};
        vecs[1] = '{3, 3,  60, 1, 4'hD};
        vecs[2] = '{0, 0,  40, 1, 4'h1};
        vecs[3] = '{1, 2,  22, 0, 4'h1};
        vecs[4] = '{1, 2,  23, 1, 4'h6};
        vecs[5] = '{0, 2,  30, 1, 4'h3};
        vecs[6] = '{2, 3,  30, 1, 4'hC};

        // Reset values and idle scanning
        repeat (3) @(negedge clk);
        check("reset_row",   {28'd0, kp.row},      32'hE);
        check("reset_code",  {28'd0, kp.key_code}, 32'h0);
        check("reset_valid", {31'd0, kp.key_valid}, 32'h0);
        check("reset_held",  {31'd0, kp.key_held},  32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("idle_row", {28'd0, kp.row}, {28'd0, row_pat[i % 4]});
            repeat (8) @(negedge clk);
        end
        check("idle_no_valid", pulses, 0);
        check("idle_held", {31'd0, kp.key_held}, 32'h0);

        // Table-driven single-key presses
        for (int v = 0; v < 7; v++) begin
            wait_row(vecs[v].r);
            p0 = pulses;
            keys[vecs[v].r*4 + vecs[v].c] = 1'b1;
            repeat (vecs[v].hold) @(negedge clk);
            keys = 16'd0;
            repeat (12) @(negedge clk);
            check("held_after_release", {31'd0, kp.key_held}, vecs[v].exp_pulses);
            repeat (18) @(negedge clk);
            check("held_cleared", {31'd0, kp.key_held}, 32'h0);
            check("pulse_count", pulses - p0, vecs[v].exp_pulses);
            check("key_code", {28'd0, kp.key_code}, {28'd0, vecs[v].exp_code});
        end

        // Bounce on row0/col3: five cycles in press debounce, then scan row1
        wait_row(0);
        p0 = pulses;
        keys[3] = 1'b1;
        repeat (13) @(negedge clk);
        keys = 16'd0;
        repeat (5) @(negedge clk);
        check("bounce_row_next", {28'd0, kp.row}, 32'hD);
        check("bounce_no_valid", pulses - p0, 0);
        check("bounce_code_kept", {28'd0, kp.key_code}, 32'hC);
        repeat (20) @(negedge clk);

        // Release bounce on key 5
        wait_row(1);
        p0 = pulses;
        keys[5] = 1'b1;
        repeat (60) @(negedge clk);
        keys[5] = 1'b0;
        repeat (6) @(negedge clk);
        keys[5] = 1'b1;
        check("rel_bounce_held", {31'd0, kp.key_held}, 32'h1);
        repeat (40) @(negedge clk);
        keys[5] = 1'b0;
        repeat (30) @(negedge clk);
        check("rel_bounce_pulses", pulses - p0, 1);
        check("rel_bounce_code", {28'd0, kp.key_code}, 32'h5);
        check("rel_bounce_held_off", {31'd0, kp.key_held}, 32'h0);

        // Two keys on row3: col0 (E) and col2 (F)
        wait_row(3);
        p0 = pulses;
        keys[12] = 1'b1;
        keys[14] = 1'b1;
        repeat (60) @(negedge clk);
        keys = 16'd0;
        repeat (30) @(negedge clk);
`ifdef KEYPAD_GHOST_REJECT_EN
        check("ghost_pulses", pulses - p0, 0);
        check("ghost_code", {28'd0, kp.key_code}, 32'h5);
`else
        check("ghost_pulses", pulses - p0, 1);
        check("ghost_code", {28'd0, kp.key_code}, 32'hE);
`endif

        // Reset during press debounce of key 9
        wait_row(2);
        keys[10] = 1'b1;
        repeat (12) @(negedge clk);
        p0 = pulses;
        reset_n = 1'b0;
        #1;
        check("rst_mid_row",   {28'd0, kp.row},       32'hE);
        check("rst_mid_code",  {28'd0, kp.key_code},  32'h0);
        check("rst_mid_valid", {31'd0, kp.key_valid}, 32'h0);
        check("rst_mid_held",  {31'd0, kp.key_held},  32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_no_early_valid", pulses - p0, 0);
        check("rst_no_early_held", {31'd0, kp.key_held}, 32'h0);
        repeat (20) @(negedge clk);
        check("rst_new_press_pulse", pulses - p0, 1);
        check("rst_new_press_code", {28'd0, kp.key_code}, 32'h9);
        keys = 16'd0;
        repeat (30) @(negedge clk);

        check("single_cycle_valid", double_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
